// File: rtl/hfusion_pkg.sv
// Shared types and helpers for the hfuse feedback frame store.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hfusion_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_FUSE  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } hstate_t;

    // Address width needed to cover a frame of n pixels (at least 1 bit).
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hvalid_delay.sv
// Fixed-depth 1-bit delay line turning core-valid into write-valid.
// Latency: exactly DEPTH cycles from d to q.
// Backpressure: none; shifts every cycle so gaps in d are preserved.
module hvalid_delay #(
    parameter int DEPTH = 21
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    // Shift d in at bit 0 each cycle; the oldest sample falls out of the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                sr[i] <= sr[i-1];
            end
            sr[0] <= d;
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/hfuse_feedback_buffer.sv
// Frame store closing the loop around the fusion core; seeds, fuses, then drains the final frame.
// Latency: core outputs 1 cycle after step, write-back PIPE_LAT cycles later, drain data 1 cycle after drain_en.
// Backpressure: none; step/drain_en are qualified by state and ignored where they do not apply.
module hfuse_feedback_buffer
    import hfusion_pkg::*;
#(
    parameter int FUSEDIMAGE_DATA_WIDTH = 8,
    parameter int HIM_LEN               = 520,
    parameter int HIM_WID               = 520,
    parameter int LOG2_NO_OF_IMAGES     = 4,
    parameter int PIPE_LAT              = 21
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             step,
    input  logic [7:0]                       hnew_in,
    input  logic [7:0]                       href_in,
    output logic [7:0]                       hnew_o,
    output logic [7:0]                       href_o,
    output logic [FUSEDIMAGE_DATA_WIDTH-1:0] hfuse_o,
    output logic                             core_valid_o,
    input  logic [FUSEDIMAGE_DATA_WIDTH-1:0] hout_newfused_bus,
    input  logic                             drain_en,
    output logic [FUSEDIMAGE_DATA_WIDTH-1:0] fused_out,
    output logic                             fused_valid,
    output logic                             busy,
    output logic                             done
);

    localparam int FW = FUSEDIMAGE_DATA_WIDTH;
    localparam int N  = HIM_LEN * HIM_WID;
    localparam int AW = addr_width(N);
    localparam int IW = LOG2_NO_OF_IMAGES;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [IW-1:0] LAST_IMG  = '1;
    localparam logic [IW-1:0] IMG_ONE   = IW'(1);

    hstate_t        state_q;
    logic [AW-1:0]  rd_addr;
    logic [AW-1:0]  wr_addr;
    logic [AW-1:0]  drain_addr;
    logic [IW-1:0]  img_cnt;
    logic [IW-1:0]  wr_img_cnt;
    logic           seed_q;
    logic [FW-1:0]  mem_q;
    logic           wr_valid;

    logic [FW-1:0]  mem [N];

    logic           pix_step;
    logic           drain_issue;
    logic           rd_wrap;
    logic           wr_wrap;
    logic           drain_last;
    logic [AW-1:0]  mem_rd_addr;

    // Steps count only while a burst can accept pixels; the IDLE step is pixel 0 of the seed frame.
    assign pix_step    = step && ((state_q == ST_IDLE) || (state_q == ST_SEED) || (state_q == ST_FUSE));
    assign drain_issue = drain_en && (state_q == ST_DONE);
    assign rd_wrap     = pix_step && (rd_addr == LAST_ADDR);
    assign wr_wrap     = wr_valid && (wr_addr == LAST_ADDR);
    assign drain_last  = drain_addr == LAST_ADDR;
    assign mem_rd_addr = (state_q == ST_DONE) ? drain_addr : rd_addr;

    // The seed image fuses with itself, later images with the stored previous result.
    assign hfuse_o   = seed_q ? FW'(hnew_o) : mem_q;
    assign fused_out = mem_q;

    // Write port: the core's result lands at wr_addr; read-before-write gives old data on a collision.
    always_ff @(posedge clk) begin
        if (wr_valid) begin
            mem[wr_addr] <= hout_newfused_bus;
        end
    end

    // Read port shared by the fuse path and the drain path, one cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (pix_step || drain_issue) begin
            mem_q <= mem[mem_rd_addr];
        end
    end

    // Register source pixels alongside the memory read so all three core inputs align.
    always_ff @(posedge clk) begin
        if (rst) begin
            hnew_o       <= '0;
            href_o       <= '0;
            seed_q       <= 1'b0;
            core_valid_o <= 1'b0;
        end else begin
            core_valid_o <= pix_step;
            if (pix_step) begin
                hnew_o <= hnew_in;
                href_o <= href_in;
                seed_q <= (state_q != ST_FUSE);
            end
        end
    end

    hvalid_delay #(
        .DEPTH(PIPE_LAT)
    ) u_wr_delay (
        .clk(clk),
        .rst(rst),
        .d  (core_valid_o),
        .q  (wr_valid)
    );

    // Write address and image counter advance with each write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr    <= '0;
            wr_img_cnt <= '0;
        end else if (wr_valid) begin
            wr_addr <= wr_wrap ? '0 : wr_addr + ADDR_ONE;
            if (wr_wrap) begin
                wr_img_cnt <= wr_img_cnt + IMG_ONE;
            end
        end
    end

    // Burst sequencing: read addressing, image counting, flush wait and drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rd_addr     <= '0;
            img_cnt     <= '0;
            drain_addr  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fused_valid <= 1'b0;
        end else begin
            fused_valid <= drain_issue;
            if (pix_step) begin
                rd_addr <= rd_wrap ? '0 : rd_addr + ADDR_ONE;
                if (rd_wrap) begin
                    img_cnt <= img_cnt + IMG_ONE;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (step) begin
                        state_q <= ST_SEED;
                        busy    <= 1'b1;
                    end
                end
                ST_SEED: begin
                    if (rd_wrap) begin
                        state_q <= ST_FUSE;
                    end
                end
                ST_FUSE: begin
                    if (rd_wrap && (img_cnt == LAST_IMG)) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // The final write of the last image closes the burst.
                    if (wr_wrap && (wr_img_cnt == LAST_IMG)) begin
                        state_q    <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        drain_addr <= '0;
                    end
                end
                ST_DONE: begin
                    if (drain_issue) begin
                        drain_addr <= drain_last ? '0 : drain_addr + ADDR_ONE;
                        if (drain_last) begin
                            state_q <= ST_IDLE;
                            done    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hfuse_feedback_buffer.sv
// Directed bench for hfuse_feedback_buffer on a 4x4 frame, two images, PIPE_LAT=3.
// Latency: core model returns hfuse_o+1 three cycles after presentation.
// Backpressure: none; stimulus is a linear sequence of directed steps.
module tb_hfuse_feedback_buffer;

    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          step;
    logic [7:0]    hnew_in;
    logic [7:0]    href_in;
    logic [7:0]    hnew_o;
    logic [7:0]    href_o;
    logic [FW-1:0] hfuse_o;
    logic          core_valid_o;
    logic [FW-1:0] hout_newfused_bus;
    logic          drain_en;
    logic [FW-1:0] fused_out;
    logic          fused_valid;
    logic          busy;
    logic          done;

    logic [FW-1:0] c0, c1, c2;
    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // Fusion core stand-in: hout = hfuse_o + 1, three cycles later.
    always @(posedge clk) begin
        c0 <= hfuse_o + 8'd1;
        c1 <= c0;
        c2 <= c1;
    end
    assign hout_newfused_bus = c2;

    hfuse_feedback_buffer #(
        .FUSEDIMAGE_DATA_WIDTH(FW),
        .HIM_LEN(4),
        .HIM_WID(4),
        .LOG2_NO_OF_IMAGES(1),
        .PIPE_LAT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .step(step),
        .hnew_in(hnew_in),
        .href_in(href_in),
        .hnew_o(hnew_o),
        .href_o(href_o),
        .hfuse_o(hfuse_o),
        .core_valid_o(core_valid_o),
        .hout_newfused_bus(hout_newfused_bus),
        .drain_en(drain_en),
        .fused_out(fused_out),
        .fused_valid(fused_valid),
        .busy(busy),
        .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One pixel step followed by gap-1 idle cycles.
    task automatic pix(input logic [7:0] v, input logic [7:0] expf, input int gap);
        step    = 1'b1;
        hnew_in = v;
        href_in = v ^ 8'h5A;
        tick();
        chk("core_valid", 32'(core_valid_o), 32'd1);
        chk("hnew_o", 32'(hnew_o), 32'(v));
        chk("href_o", 32'(href_o), 32'(v ^ 8'h5A));
        chk("hfuse_o", 32'(hfuse_o), 32'(expf));
        chk("busy_burst", 32'(busy), 32'd1);
        chk("no_fused_valid", 32'(fused_valid), 32'd0);
        if (gap > 1) begin
            step = 1'b0;
            repeat (gap - 1) begin
                tick();
                chk("valid_gap", 32'(core_valid_o), 32'd0);
            end
        end
    endtask

    // Bounded wait for the flush to finish, optionally holding step to show it is ignored.
    task automatic wait_done(input logic hold_step);
        logic cv_seen;
        int   t;
        cv_seen = 1'b0;
        t       = 0;
        step    = hold_step;
        hnew_in = 8'hEE;
        while (!done && t < 40) begin
            tick();
            cv_seen = cv_seen | core_valid_o;
            t++;
        end
        chk("done_set", 32'(done), 32'd1);
        chk("busy_clear", 32'(busy), 32'd0);
        chk("flush_ignores_step", 32'(cv_seen), 32'd0);
        if (hold_step) begin
            repeat (3) begin
                tick();
                chk("done_ignores_step", 32'(core_valid_o), 32'd0);
                chk("done_no_spurious_drain", 32'(fused_valid), 32'd0);
            end
        end
        step = 1'b0;
    endtask

    // Drain the 16-pixel frame, expected value p+2 at drain index p.
    task automatic drain(input int gap);
        for (int p = 0; p < 16; p++) begin
            drain_en = 1'b1;
            tick();
            drain_en = 1'b0;
            chk("fused_valid", 32'(fused_valid), 32'd1);
            chk("fused_out", 32'(fused_out), 32'(p + 2));
            if (p == 14) chk("done_held", 32'(done), 32'd1);
            if (p == 15) begin
                chk("done_dropped", 32'(done), 32'd0);
                chk("busy_after_drain", 32'(busy), 32'd0);
            end
            if (gap > 1) begin
                repeat (gap - 1) begin
                    tick();
                    chk("fused_valid_gap", 32'(fused_valid), 32'd0);
                end
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        step     = 1'b0;
        drain_en = 1'b0;
        hnew_in  = 8'h00;
        href_in  = 8'h00;
        tick();
        tick();
        chk("rst_hnew_o", 32'(hnew_o), 32'd0);
        chk("rst_href_o", 32'(href_o), 32'd0);
        chk("rst_hfuse_o", 32'(hfuse_o), 32'd0);
        chk("rst_core_valid", 32'(core_valid_o), 32'd0);
        chk("rst_fused_out", 32'(fused_out), 32'd0);
        chk("rst_fused_valid", 32'(fused_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Continuous burst; drain_en held through SEED must be ignored.
        drain_en = 1'b1;
        for (int p = 0; p < 16; p++) pix(8'(p), 8'(p), 1);
        drain_en = 1'b0;
        for (int p = 0; p < 16; p++) pix(8'(p), 8'(p + 1), 1);
        wait_done(1'b1);
        drain(1);

        // Gapped burst: step every third cycle, identical results expected.
        for (int p = 0; p < 16; p++) pix(8'(p), 8'(p), 3);
        for (int p = 0; p < 16; p++) pix(8'(p), 8'(p + 1), 3);
        step = 1'b0;
        wait_done(1'b0);
        drain(2);

        // Reset in the middle of FUSE at pixel 7.
        for (int p = 0; p < 16; p++) pix(8'(p), 8'(p), 1);
        for (int p = 0; p < 7; p++) pix(8'(p), 8'(p + 1), 1);
        step    = 1'b1;
        hnew_in = 8'h07;
        rst     = 1'b1;
        tick();
        rst  = 1'b0;
        step = 1'b0;
        chk("midrst_hnew_o", 32'(hnew_o), 32'd0);
        chk("midrst_hfuse_o", 32'(hfuse_o), 32'd0);
        chk("midrst_core_valid", 32'(core_valid_o), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_fused_valid", 32'(fused_valid), 32'd0);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_core_valid", 32'(core_valid_o), 32'd0);
        step    = 1'b1;
        hnew_in = 8'h42;
        href_in = 8'h24;
        tick();
        step = 1'b0;
        chk("restart_core_valid", 32'(core_valid_o), 32'd1);
        chk("restart_seed_hfuse", 32'(hfuse_o), 32'h42);
        chk("restart_href_o", 32'(href_o), 32'h24);
        chk("restart_busy", 32'(busy), 32'd1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
